// File: rtl/fb_pkg.sv
// Shared geometry, types and address helper for the
// paint framebuffer port arbiter.
package fb_pkg;

  localparam int unsigned FB_W   = 320;
  localparam int unsigned FB_H   = 240;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned ADDR_W = 17;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  // Row-major linear address; callers narrow to their own width.
  function automatic logic [31:0] fb_addr(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] w
  );
    return y * w + x;
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Full-screen clear sequencer: walks every framebuffer address
// once, writing the captured colour in each free RAM slot.
module fb_clear_seq #(
  parameter int unsigned FB_W   = 320,
  parameter int unsigned FB_H   = 240,
  parameter int unsigned PIX_W  = 4,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              pixel_clk_25,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  color,
  input  logic              slot_free,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data,
  output logic              busy,
  output logic              done
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_W * FB_H - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  color_q, color_d;

  always_ff @(posedge pixel_clk_25 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    we      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          addr_d  = '0;
          color_d = color;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (slot_free) begin
          we = 1'b1;
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr = addr_q;
  assign data = color_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display fetch on even active x,
// clear or paint writes in every other slot, 2-cycle sync alignment.
module fb_port_arbiter #(
  parameter int unsigned FB_W   = 320,
  parameter int unsigned FB_H   = 240,
  parameter int unsigned PIX_W  = 4,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              pixel_clk_25,
  input  logic              reset,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic              vid_active,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clr_req,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pix_idx,
  output logic              hsync_d,
  output logic              vsync_d,
  output logic              vid_active_d
);
  import fb_pkg::*;

  logic              disp_slot;
  logic              free_slot;
  logic              wr_in_range;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] paint_addr;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_data;

  logic              rd_pend_q, rd_pend_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [1:0]        hs_pipe_q, hs_pipe_d;
  logic [1:0]        vs_pipe_q, vs_pipe_d;
  logic [1:0]        va_pipe_q, va_pipe_d;

  fb_clear_seq #(
    .FB_W   (FB_W),
    .FB_H   (FB_H),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .pixel_clk_25 (pixel_clk_25),
    .reset        (reset),
    .start        (clr_req),
    .color        (clr_color),
    .slot_free    (free_slot),
    .we           (clr_we),
    .addr         (clr_addr),
    .data         (clr_data),
    .busy         (clr_busy),
    .done         (clr_done)
  );

  always_comb begin
    disp_slot   = vid_active && !x_pos[0];
    free_slot   = !disp_slot;
    wr_in_range = ({23'd0, wr_x} < FB_W) &&
                  ({24'd0, wr_y} < FB_H);
    disp_addr   = ADDR_W'(fb_addr(32'(x_pos >> 1),
                                  32'(y_pos >> 1), FB_W));
    paint_addr  = ADDR_W'(fb_addr(32'(wr_x),
                                  32'(wr_y), FB_W));
    wr_ready    = !reset && free_slot && !clr_busy;
  end

  // Display wins outright; clear owns free slots while busy.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (reset) begin
      ram_we = 1'b0;
    end else if (disp_slot) begin
      ram_addr = disp_addr;
    end else if (clr_busy) begin
      ram_addr  = clr_addr;
      ram_we    = clr_we;
      ram_wdata = clr_data;
    end else if (wr_valid) begin
      ram_addr  = paint_addr;
      ram_we    = wr_in_range;
      ram_wdata = wr_data;
    end
  end

  always_comb begin
    rd_pend_d = disp_slot;
    pix_d     = rd_pend_q ? ram_rdata : pix_q;
    hs_pipe_d = {hs_pipe_q[0], hsync};
    vs_pipe_d = {vs_pipe_q[0], vsync};
    va_pipe_d = {va_pipe_q[0], vid_active};
  end

  always_ff @(posedge pixel_clk_25 or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      pix_q     <= '0;
      hs_pipe_q <= 2'b11;
      vs_pipe_q <= 2'b11;
      va_pipe_q <= 2'b00;
    end else begin
      rd_pend_q <= rd_pend_d;
      pix_q     <= pix_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      va_pipe_q <= va_pipe_d;
    end
  end

  assign hsync_d      = hs_pipe_q[1];
  assign vsync_d      = vs_pipe_q[1];
  assign vid_active_d = va_pipe_q[1];
  assign pix_idx      = va_pipe_q[1] ? pix_q : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: vector table, hand sequences and
// random traffic against a framebuffer-level reference model.
module tb_fb_port_arbiter;

  localparam int W = 320;
  localparam int H = 16;
  localparam int N = W * H;

  logic       pixel_clk_25 = 1'b0;
  logic       reset;
  logic [9:0] x_pos, y_pos;
  logic       vid_active, hsync, vsync;
  logic       wr_valid, wr_ready;
  logic [8:0] wr_x;
  logic [7:0] wr_y;
  logic [3:0] wr_data;
  logic       clr_req;
  logic [3:0] clr_color;
  logic       clr_busy, clr_done;
  logic [16:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata, ram_rdata;
  logic [3:0] pix_idx;
  logic       hsync_d, vsync_d, vid_active_d;

  always #20 pixel_clk_25 = ~pixel_clk_25;

  fb_port_arbiter #(
    .FB_W(W), .FB_H(H), .PIX_W(4), .ADDR_W(17)
  ) dut (
    .pixel_clk_25 (pixel_clk_25),
    .reset        (reset),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .vid_active   (vid_active),
    .hsync        (hsync),
    .vsync        (vsync),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .clr_req      (clr_req),
    .clr_color    (clr_color),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .pix_idx      (pix_idx),
    .hsync_d      (hsync_d),
    .vsync_d      (vsync_d),
    .vid_active_d (vid_active_d)
  );

  // Behavioural single-port BRAM, read data one cycle later.
  logic [3:0] ram [0:131071];
  logic       ram_init;
  always @(posedge pixel_clk_25) begin
    if (ram_init) begin
      for (int i = 0; i < 131072; i++) ram[i] <= '0;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model state
  logic [3:0] exp_mem [0:131071];
  int  clr_left, clr_next, clr_col;
  bit  done_now;
  int  va_h[$], hs_h[$], vs_h[$], lat_h[$];

  bit  obs_rdy, obs_we, obs_busy, obs_done, obs_hs, last_rdy;
  int  obs_addr, obs_pix;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d",
               nm, cyc_n, act, exp);
    end
  endtask

  task automatic mreset();
    clr_left = 0;
    clr_next = 0;
    done_now = 0;
    va_h.delete(); hs_h.delete(); vs_h.delete(); lat_h.delete();
    repeat (2) begin
      va_h.push_back(0); hs_h.push_back(1);
      vs_h.push_back(1); lat_h.push_back(0);
    end
  endtask

  task automatic idle_inputs();
    x_pos = '0; y_pos = '0; vid_active = 0;
    hsync = 1; vsync = 1;
    wr_valid = 0; wr_x = '0; wr_y = '0; wr_data = '0;
    clr_req = 0; clr_color = '0;
  endtask

  // One clock: check at negedge against the model, then advance it.
  task automatic cyc();
    bit disp, busy, rdy, inr, dn;
    int a, wa, lat;
    @(negedge pixel_clk_25);
    disp = vid_active && !x_pos[0];
    busy = (clr_left > 0) || done_now;
    rdy  = !disp && !busy;
    inr  = (int'(wr_x) < W) && (int'(wr_y) < H);
    a    = (int'(y_pos) / 2) * W + int'(x_pos) / 2;
    wa   = int'(wr_y) * W + int'(wr_x);
    obs_rdy = wr_ready; obs_we = ram_we; obs_addr = ram_addr;
    obs_pix = pix_idx; obs_hs = hsync_d;
    obs_busy = clr_busy; obs_done = clr_done;
    chk("wr_ready", wr_ready, rdy);
    chk("clr_busy", clr_busy, busy);
    chk("clr_done", clr_done, done_now);
    if (disp) begin
      chk("disp_we", ram_we, 0);
      chk("disp_addr", ram_addr, a);
    end else if (clr_left > 0) begin
      chk("clr_we", ram_we, 1);
      chk("clr_addr", ram_addr, clr_next);
      chk("clr_wdata", ram_wdata, clr_col);
    end else if (rdy && wr_valid) begin
      chk("wr_we", ram_we, inr);
      if (inr) begin
        chk("wr_addr", ram_addr, wa);
        chk("wr_wdata", ram_wdata, wr_data);
      end
    end else begin
      chk("idle_we", ram_we, 0);
    end
    chk("pix_idx", pix_idx, va_h[0] ? lat_h[0] : 0);
    chk("hsync_d", hsync_d, hs_h[0]);
    chk("vsync_d", vsync_d, vs_h[0]);
    chk("vid_active_d", vid_active_d, va_h[0]);
    last_rdy = rdy;
    @(posedge pixel_clk_25);
    cyc_n++;
    lat = disp ? int'(exp_mem[a]) : lat_h[1];
    va_h.push_back(vid_active); void'(va_h.pop_front());
    hs_h.push_back(hsync);      void'(hs_h.pop_front());
    vs_h.push_back(vsync);      void'(vs_h.pop_front());
    lat_h.push_back(lat);       void'(lat_h.pop_front());
    dn = 0;
    if (clr_left > 0 && !disp) begin
      exp_mem[clr_next] = 4'(clr_col);
      clr_next++;
      clr_left--;
      if (clr_left == 0) dn = 1;
    end
    if (rdy && wr_valid && inr) exp_mem[wa] = wr_data;
    if (!busy && clr_req) begin
      clr_left = N;
      clr_next = 0;
      clr_col  = clr_color;
    end
    done_now = dn;
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    @(negedge pixel_clk_25);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_pix_idx", pix_idx, 0);
    chk("rst_hsync_d", hsync_d, 1);
    chk("rst_vsync_d", vsync_d, 1);
    chk("rst_vid_active_d", vid_active_d, 0);
    @(posedge pixel_clk_25);
    #1;
    reset = 0;
    mreset();
  endtask

  task automatic rnd_timing();
    vid_active = 1'($urandom_range(0, 1));
    x_pos = 10'($urandom_range(0, 639));
    y_pos = 10'($urandom_range(0, 479));
    hsync = 1'($urandom_range(0, 1));
    vsync = 1'($urandom_range(0, 1));
  endtask

  task automatic rnd_wr();
    if (!(wr_valid && !last_rdy)) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_x = 9'($urandom_range(0, 330));
      wr_y = 8'($urandom_range(0, 18));
      wr_data = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic run_to_idle(output int dones);
    int guard;
    guard = 0;
    dones = 0;
    while ((clr_left > 0 || done_now) && guard < 30000) begin
      rnd_timing();
      rnd_wr();
      cyc();
      if (obs_done) dones++;
      guard++;
    end
    if (guard >= 30000) chk("clear_timeout", guard, 0);
  endtask

  typedef struct {
    bit va; int x; int y;
    bit wv; int wx; int wy; int wd;
    bit e_rdy; bit e_we; bit c_addr; int e_addr; int e_wd;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] hs_pat = 8'b1101_1001;
  int   p_addr[8], p_pix[8], p_hs[8];
  int   bad, dones;

  initial begin
    for (int i = 0; i < 131072; i++) exp_mem[i] = '0;
    last_rdy = 0;
    ram_init = 1;
    do_reset();
    ram_init = 0;

    vecs.push_back('{0, 0, 0, 1, 10, 5, 7, 1, 1, 1, 1610, 7});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 3, 1, 1, 1, 0, 3});
    vecs.push_back('{0, 0, 0, 1, 1, 0, 9, 1, 1, 1, 1, 9});
    vecs.push_back('{0, 0, 0, 1, 320, 0, 2, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 5, 16, 2, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 319, 15, 4, 1, 1, 1, 5119, 4});
    vecs.push_back('{1, 4, 2, 1, 3, 3, 6, 0, 0, 1, 322, 0});
    vecs.push_back('{1, 5, 2, 1, 3, 3, 6, 1, 1, 1, 963, 6});
    vecs.push_back('{1, 638, 479, 0, 0, 0, 0, 0, 0, 1, 76799, 0});
    vecs.push_back('{1, 639, 479, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    foreach (vecs[i]) begin
      vid_active = vecs[i].va;
      x_pos = 10'(vecs[i].x); y_pos = 10'(vecs[i].y);
      wr_valid = vecs[i].wv;
      wr_x = 9'(vecs[i].wx); wr_y = 8'(vecs[i].wy);
      wr_data = 4'(vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_ready", i), wr_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_we", i), ram_we, vecs[i].e_we);
      if (vecs[i].c_addr)
        chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
      if (vecs[i].e_we)
        chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].e_wd);
      cyc();
    end
    idle_inputs();

    // Active line start: fb(0,0)=3, fb(1,0)=9.
    for (int i = 0; i < 8; i++) begin
      vid_active = 1; y_pos = '0; x_pos = 10'(i);
      hsync = hs_pat[i];
      cyc();
      p_addr[i] = obs_addr; p_pix[i] = obs_pix; p_hs[i] = obs_hs;
    end
    chk("line_addr_x0", p_addr[0], 0);
    chk("line_addr_x2", p_addr[2], 1);
    chk("line_pix_t2", p_pix[2], 3);
    chk("line_pix_t3", p_pix[3], 3);
    chk("line_pix_t4", p_pix[4], 9);
    chk("line_pix_t5", p_pix[5], 9);
    for (int i = 2; i < 8; i++)
      chk($sformatf("line_hsync_d%0d", i), p_hs[i], hs_pat[i-2]);

    // Held write during active video: only odd x slots accept.
    hsync = 1;
    wr_valid = 1; wr_x = 9'd20; wr_y = 8'd1; wr_data = 4'd11;
    for (int i = 8; i < 16; i++) begin
      vid_active = 1; y_pos = 10'd2; x_pos = 10'(i);
      cyc();
      chk($sformatf("act_ready_x%0d", i), obs_rdy, i % 2);
      if (i % 2 == 0) chk($sformatf("act_we_x%0d", i), obs_we, 0);
    end
    idle_inputs();

    // Full clear with colour 5 under mixed display traffic.
    clr_req = 1; clr_color = 4'd5;
    cyc();
    clr_req = 0;
    cyc();
    chk("clr_busy_rise", obs_busy, 1);
    run_to_idle(dones);
    chk("clr_done_pulses", dones, 1);
    bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] != 4'd5) bad++;
    chk("clr_all_written_5", bad, 0);

    // Reset while the clear is at address 1000.
    idle_inputs();
    wr_valid = 0;
    clr_req = 1; clr_color = 4'd12;
    cyc();
    clr_req = 0;
    bad = 0;
    while (clr_next < 1000 && bad < 5000) begin
      rnd_timing(); cyc(); bad++;
    end
    chk("abort_reached_1000", clr_next, 1000);
    do_reset();
    cyc();
    chk("abort_busy", obs_busy, 0);
    chk("abort_we", obs_we, 0);
    chk("abort_done", obs_done, 0);
    clr_req = 1; clr_color = 4'd3;
    cyc();
    clr_req = 0;
    cyc();
    chk("restart_we", obs_we, 1);
    chk("restart_addr", obs_addr, 0);
    run_to_idle(dones);
    chk("restart_done_pulses", dones, 1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      rnd_timing();
      rnd_wr();
      clr_req = ($urandom_range(0, 499) == 0);
      clr_color = 4'($urandom_range(0, 15));
      cyc();
    end
    idle_inputs();
    run_to_idle(dones);
    repeat (2) cyc();
    bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] != exp_mem[i]) bad++;
    chk("final_mem_image", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
